obj_oam_scanner: RTL

Per-scanline OAM evaluation stage of the OBJ pipeline. On a start pulse it walks OAM entries 0..127 in order, decodes shape/size, and applies the affine double-size rule and the disable rule. Each sprite whose vertical extent covers the requested row is emitted as a descriptor over a valid/ready stream. The downstream OBJ pixel/render stage consumes the stream and does the per-pixel preimage check, transparency and palette formation.

---
 rtl/obj_oam_scanner.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/obj_oam_scanner.sv
// Per-scanline OAM evaluation: walks entries 0..127, decodes sprite height and
// emits every sprite covering the requested row as a valid/ready descriptor.
module obj_oam_scanner #(
    parameter int MAX_OBJS = 128
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  row,
    output logic        busy,
    output logic        done,
    output logic [7:0]  oam_addr,
    output logic        oam_re,
    input  logic [31:0] oam_rdata,
    output logic        obj_valid,
    input  logic        obj_ready,
    output logic [6:0]  obj_index,
    output logic [15:0] obj_attr0,
    output logic [15:0] obj_attr1,
    output logic [15:0] obj_attr2,
    output logic [6:0]  obj_line,
    output logic [7:0]  obj_count
);

    localparam logic [7:0] MAX_CNT = 8'(MAX_OBJS);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH_A, S_FETCH_B, S_EVAL, S_EMIT, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  row_q;
    logic [6:0]  idx_q;
    logic [15:0] attr0_q, attr1_q, attr2_q;
    logic [6:0]  line_q;
    logic [7:0]  count_q;

    logic [7:0]  height, eff_height, diff, count_inc;
    logic        visible, last_idx, max_hit;

    // Height from {shape, size}; shape 3 is prohibited and yields 0.
    always_comb begin
        height = 8'd0;
        unique case ({attr0_q[15:14], attr1_q[15:14]})
            4'b00_00: height = 8'd8;
            4'b00_01: height = 8'd16;
            4'b00_10: height = 8'd32;
            4'b00_11: height = 8'd64;
            4'b01_00: height = 8'd8;
            4'b01_01: height = 8'd8;
            4'b01_10: height = 8'd16;
            4'b01_11: height = 8'd32;
            4'b10_00: height = 8'd16;
            4'b10_01: height = 8'd32;
            4'b10_10: height = 8'd32;
            4'b10_11: height = 8'd64;
            default:  height = 8'd0;
        endcase
    end

    // Double-size doubles the box (max 128 still fits 8 bits); diff wraps mod 256.
    assign eff_height = (attr0_q[9:8] == 2'b11) ? {height[6:0], 1'b0} : height;
    assign diff       = row_q - attr0_q[7:0];
    assign visible    = (attr0_q[15:14] != 2'b11) && (attr0_q[9:8] != 2'b10) &&
                        (diff < eff_height);
    assign last_idx   = (idx_q == 7'd127);
    assign count_inc  = count_q + 8'd1;
    assign max_hit    = (count_inc == MAX_CNT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_FETCH_A;
            S_FETCH_A: state_d = S_FETCH_B;
            S_FETCH_B: state_d = S_EVAL;
            S_EVAL: begin
                if (visible)       state_d = S_EMIT;
                else if (last_idx) state_d = S_DONE;
                else               state_d = S_FETCH_A;
            end
            S_EMIT: begin
                if (obj_ready) state_d = (max_hit || last_idx) ? S_DONE : S_FETCH_A;
            end
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        oam_re    = 1'b0;
        oam_addr  = 8'd0;
        obj_valid = 1'b0;
        unique case (state_q)
            S_FETCH_A: begin busy = 1'b1; oam_re = 1'b1; oam_addr = {idx_q, 1'b0}; end
            S_FETCH_B: begin busy = 1'b1; oam_re = 1'b1; oam_addr = {idx_q, 1'b1}; end
            S_EVAL:    busy = 1'b1;
            S_EMIT:    begin busy = 1'b1; obj_valid = 1'b1; end
            S_DONE:    done = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_q   <= 8'd0;
            idx_q   <= 7'd0;
            attr0_q <= 16'd0;
            attr1_q <= 16'd0;
            attr2_q <= 16'd0;
            line_q  <= 7'd0;
            count_q <= 8'd0;
        end else begin
            unique case (state_q)
                S_IDLE: if (start) begin
                    row_q   <= row;
                    idx_q   <= 7'd0;
                    count_q <= 8'd0;
                end
                S_FETCH_B: begin
                    attr0_q <= oam_rdata[15:0];
                    attr1_q <= oam_rdata[31:16];
                end
                S_EVAL: begin
                    attr2_q <= oam_rdata[15:0];
                    line_q  <= diff[6:0];
                    if (!visible && !last_idx) idx_q <= idx_q + 7'd1;
                end
                S_EMIT: if (obj_ready) begin
                    count_q <= count_inc;
                    if (!(max_hit || last_idx)) idx_q <= idx_q + 7'd1;
                end
                default: ;
            endcase
        end
    end

    assign obj_index = idx_q;
    assign obj_attr0 = attr0_q;
    assign obj_attr1 = attr1_q;
    assign obj_attr2 = attr2_q;
    assign obj_line  = line_q;
    assign obj_count = count_q;

endmodule
